// File: rtl/spi_if.sv
// spi_if: SPI master bus bundle (request side plus serial pins).
interface spi_if #(
    parameter int DATA_WIDTH = 7
) ();
    logic [DATA_WIDTH-1:0] data_in;
    logic                  MISO;
    logic                  send;
    logic                  MOSI;
    logic                  SCLK;
    logic                  SS;
    logic                  done;

    modport master (input data_in, MISO, send, output MOSI, SCLK, SS, done);
    modport slave  (output data_in, MISO, send, input MOSI, SCLK, SS, done);
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI mode 0 master, MSB first, programmable SCLK half-period.
module spi_master #(
    parameter int DATA_WIDTH = 7,
    parameter int CLK_DIV    = 1
) (
    input  logic  clk,
    input  logic  rst,
    spi_if.master bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int VW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(DATA_WIDTH);
    localparam logic [VW-1:0] DIV_END = VW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] tx;
    logic [DATA_WIDTH-1:0] rx;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [CW-1:0]         bit_cnt;
    logic [VW-1:0]         div_cnt;
    logic                  half_end;

    assign tx_sh    = tx << 1;
    assign half_end = div_cnt == DIV_END;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= '0;
            rx       <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            bus.SS   <= 1'b1;
            bus.SCLK <= 1'b0;
            bus.MOSI <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.send) begin
                    tx       <= bus.data_in;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    bus.SS   <= 1'b0;
                    bus.MOSI <= bus.data_in[DATA_WIDTH-1];
                    state    <= SETUP;
                end
                SETUP: if (half_end) begin
                    div_cnt  <= '0;
                    bus.SCLK <= 1'b1;
                    rx       <= (rx << 1) | DATA_WIDTH'(bus.MISO);
                    state    <= XFER;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                XFER: if (!half_end) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    if (bus.SCLK) begin
                        bus.SCLK <= 1'b0;
                        tx       <= tx_sh;
                        bus.MOSI <= tx_sh[DATA_WIDTH-1];
                        bit_cnt  <= bit_cnt + 1'b1;
                    end else if (bit_cnt == LAST) begin
                        // the last bit's low half-period has elapsed
                        bus.SS   <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        bus.SCLK <= 1'b1;
                        rx       <= (rx << 1) | DATA_WIDTH'(bus.MISO);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master with CLK_DIV=1 and CLK_DIV=3.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;

    spi_if #(.DATA_WIDTH(7)) bus0 ();
    spi_if #(.DATA_WIDTH(7)) bus1 ();

    spi_master #(.DATA_WIDTH(7), .CLK_DIV(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    spi_master #(.DATA_WIDTH(7), .CLK_DIV(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one frame on the selected DUT, recording what the pins show each cycle.
    task automatic frame(input bit sel, input logic [6:0] d, input bit chg, output int lat,
                         output logic [6:0] bits, output int pulses, output int hi, output int ss_hi);
        logic s, prev, m, ss, dn;
        lat = 0; bits = '0; pulses = 0; hi = 0; ss_hi = 0; prev = 1'b0;
        if (sel) begin bus1.data_in = d; bus1.send = 1'b1; end
        else begin bus0.data_in = d; bus0.send = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin bus0.send = 1'b0; bus1.send = 1'b0; end
            if (chg && lat == 6) begin bus0.data_in = '0; bus1.data_in = '0; end
            s  = sel ? bus1.SCLK : bus0.SCLK;
            m  = sel ? bus1.MOSI : bus0.MOSI;
            ss = sel ? bus1.SS   : bus0.SS;
            dn = sel ? bus1.done : bus0.done;
            if (s && !prev) begin bits = {bits[5:0], m}; pulses++; end
            if (s) hi++;
            if (ss && !dn) ss_hi++;
            if (ss && s) ss_hi++;
            prev = s;
            if (dn) break;
        end
    endtask

    int lat, pulses, hi, ss_hi, dones, dup, run, min_gap, ss_bad;
    logic [6:0] bits;
    logic pd;

    initial begin
        bus0.data_in = '0; bus0.send = 1'b0; bus0.MISO = 1'b0;
        bus1.data_in = '0; bus1.send = 1'b0; bus1.MISO = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_ss",   bus0.SS,   1'b1);
        chk("rst_sclk", bus0.SCLK, 1'b0);
        chk("rst_mosi", bus0.MOSI, 1'b0);
        chk("rst_done", bus0.done, 1'b0);
        chk("rst_ss1",  bus1.SS,   1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ss",   bus0.SS,   1'b1);
        chk("idle_done", bus0.done, 1'b0);

        bus0.MISO = 1'b1;
        frame(1'b0, 7'h31, 1'b0, lat, bits, pulses, hi, ss_hi);
        chk("f1_lat",    lat,    16);
        chk("f1_bits",   bits,   7'h31);
        chk("f1_pulses", pulses, 7);
        chk("f1_hi",     hi,     7);
        chk("f1_ss",     ss_hi,  0);
        chk("f1_rx",     dut0.rx, 7'h7F);
        @(posedge clk); #1;
        chk("f1_done1", bus0.done, 1'b0);
        chk("f1_ssend", bus0.SS,   1'b1);

        bus0.MISO = 1'b0;
        frame(1'b0, 7'h31, 1'b1, lat, bits, pulses, hi, ss_hi);
        chk("f2_bits", bits,    7'h31);
        chk("f2_rx",   dut0.rx, 7'h00);
        chk("f2_lat",  lat,     16);
        @(posedge clk); #1;

        bus0.data_in = 7'h31; bus0.send = 1'b1;
        dones = 0; dup = 0; run = 0; min_gap = 99; pd = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(posedge clk); #1;
            if (bus0.done) dones++;
            if (bus0.done && pd) dup++;
            pd = bus0.done;
            if (bus0.SS) run++;
            else begin
                if (run > 0 && run < min_gap) min_gap = run;
                run = 0;
            end
        end
        bus0.send = 1'b0;
        chk("b2b_dones", dones,   2);
        chk("b2b_dup",   dup,     0);
        chk("b2b_gap",   min_gap, 2);
        repeat (20) @(posedge clk);
        #1;

        bus1.MISO = 1'b1;
        frame(1'b1, 7'h55, 1'b0, lat, bits, pulses, hi, ss_hi);
        chk("d3_lat",    lat,    46);
        chk("d3_bits",   bits,   7'h55);
        chk("d3_pulses", pulses, 7);
        chk("d3_hi",     hi,     21);
        chk("d3_ss",     ss_hi,  0);
        chk("d3_rx",     dut1.rx, 7'h7F);
        @(posedge clk); #1;

        bus1.data_in = 7'h55; bus1.send = 1'b1;
        @(posedge clk); #1 bus1.send = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_pre_sclk", bus1.SCLK, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ss",   bus1.SS,   1'b1);
        chk("abort_sclk", bus1.SCLK, 1'b0);
        chk("abort_rx",   dut1.rx,   7'h00);
        @(posedge clk); #1 rst = 1'b0;
        dones = 0; ss_bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus1.done) dones++;
            if (!bus1.SS || bus1.SCLK) ss_bad++;
        end
        chk("abort_done", dones,  0);
        chk("abort_idle", ss_bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
